// File: rtl/sevenseg_axil_scan.sv
// AXI4-Lite slave that drives a multiplexed seven-segment display: scan prescaler, 16-level PWM, dp/blank masks, status.
// Define SEVENSEG_BLINK_EN to add the blink mask register at 0x14 and the 32-frame blink phase.

module sevenseg_axil_scan #(
   parameter int NUM_DIGITS         = 8,
   parameter int SCAN_DIV           = 100000,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter bit SEG_ACTIVE_LOW     = 1'b1,
   parameter bit AN_ACTIVE_LOW      = 1'b1
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [31:0]                   S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [31:0]                   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [6:0]                    seg,
   output logic                          dp,
   output logic [NUM_DIGITS-1:0]         an,
   output logic                          frame_tick
);

   localparam int AWW = C_S_AXI_ADDR_WIDTH - 2;
   localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [2:0]            IDX_LAST   = 3'(NUM_DIGITS - 1);
   localparam logic [7:0]            DIG_MASK   = 8'((1 << NUM_DIGITS) - 1);
   localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? '1 : '0;

   localparam logic [AWW-1:0] A_CTRL   = AWW'(0);
   localparam logic [AWW-1:0] A_DIGITS = AWW'(1);
   localparam logic [AWW-1:0] A_DP     = AWW'(2);
   localparam logic [AWW-1:0] A_BLANK  = AWW'(3);
   localparam logic [AWW-1:0] A_STATUS = AWW'(4);
`ifdef SEVENSEG_BLINK_EN
   localparam logic [AWW-1:0] A_BLINK  = AWW'(5);
`endif

   function automatic logic [6:0] hex_decode(input logic [3:0] h);
      case (h)
         4'h0: return 7'h3F;
         4'h1: return 7'h06;
         4'h2: return 7'h5B;
         4'h3: return 7'h4F;
         4'h4: return 7'h66;
         4'h5: return 7'h6D;
         4'h6: return 7'h7D;
         4'h7: return 7'h07;
         4'h8: return 7'h7F;
         4'h9: return 7'h6F;
         4'hA: return 7'h77;
         4'hB: return 7'h7C;
         4'hC: return 7'h39;
         4'hD: return 7'h5E;
         4'hE: return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

   function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
      return r;
   endfunction

   logic        en;
   logic [3:0]  bright;
   logic [31:0] digits;
   logic [7:0]  dp_mask;
   logic [7:0]  blank_mask;
   logic [7:0]  blank_eff;
`ifdef SEVENSEG_BLINK_EN
   logic [7:0]  blink_mask;
`endif

   logic           aw_rdy, b_vld, ar_rdy, r_vld;
   logic [1:0]     b_resp, r_resp;
   logic [31:0]    r_data;
   logic           wr_en, rd_en, wr_ok, rd_ok;
   logic [AWW-1:0] wr_word, rd_word;
   logic [31:0]    rd_val;

   logic [PW-1:0]  presc;
   logic [2:0]     idx;
   logic [3:0]     pwm;
   logic [15:0]    frame_cnt;

   logic                  digit_on, lit;
   logic [6:0]            seg_raw;
   logic [7:0]            an_sel;
   logic [NUM_DIGITS-1:0] an_one;
   logic [6:0]            seg_p0, seg_p1;
   logic                  dp_p0, dp_p1, tick_p1;
   logic [NUM_DIGITS-1:0] an_p0, an_p1;

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign wr_word = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign rd_word = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign wr_en   = aw_rdy && S_AXI_AWVALID && S_AXI_WVALID;
   assign rd_en   = ar_rdy && S_AXI_ARVALID;

   always_comb begin
      wr_ok = 1'b0;
      case (wr_word)
         A_CTRL, A_DIGITS, A_DP, A_BLANK: wr_ok = 1'b1;
`ifdef SEVENSEG_BLINK_EN
         A_BLINK: wr_ok = 1'b1;
`endif
         default: wr_ok = 1'b0;
      endcase
   end

   always_comb begin
      rd_val = '0;
      rd_ok  = 1'b1;
      case (rd_word)
         A_CTRL:   rd_val = {20'h0, bright, 7'h0, en};
         A_DIGITS: rd_val = digits;
         A_DP:     rd_val = {24'h0, dp_mask};
         A_BLANK:  rd_val = {24'h0, blank_mask};
         A_STATUS: rd_val = {frame_cnt, 13'h0, idx};
`ifdef SEVENSEG_BLINK_EN
         A_BLINK:  rd_val = {24'h0, blink_mask};
`endif
         default:  rd_ok = 1'b0;
      endcase
   end

   // Write channel and register file; ready is a one-cycle pulse, never offered while B is pending
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_rdy     <= 1'b0;
         b_vld      <= 1'b0;
         b_resp     <= 2'b00;
         en         <= 1'b0;
         bright     <= 4'h0;
         digits     <= 32'h0;
         dp_mask    <= 8'h0;
         blank_mask <= 8'h0;
`ifdef SEVENSEG_BLINK_EN
         blink_mask <= 8'h0;
`endif
      end else begin
         aw_rdy <= !aw_rdy && S_AXI_AWVALID && S_AXI_WVALID && !b_vld;
         if (wr_en) begin
            b_vld  <= 1'b1;
            b_resp <= wr_ok ? 2'b00 : 2'b10;
         end else if (b_vld && S_AXI_BREADY) begin
            b_vld  <= 1'b0;
         end
         if (wr_en) begin
            case (wr_word)
               A_CTRL: begin
                  if (S_AXI_WSTRB[0]) en     <= S_AXI_WDATA[0];
                  if (S_AXI_WSTRB[1]) bright <= S_AXI_WDATA[11:8];
               end
               A_DIGITS: digits <= apply_strb(digits, S_AXI_WDATA, S_AXI_WSTRB);
               A_DP:     if (S_AXI_WSTRB[0]) dp_mask    <= S_AXI_WDATA[7:0] & DIG_MASK;
               A_BLANK:  if (S_AXI_WSTRB[0]) blank_mask <= S_AXI_WDATA[7:0] & DIG_MASK;
`ifdef SEVENSEG_BLINK_EN
               A_BLINK:  if (S_AXI_WSTRB[0]) blink_mask <= S_AXI_WDATA[7:0] & DIG_MASK;
`endif
               default: ;
            endcase
         end
      end
   end

   // Read channel: data captured at the address handshake, so a same-cycle write is not visible
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ar_rdy <= 1'b0;
         r_vld  <= 1'b0;
         r_data <= 32'h0;
         r_resp <= 2'b00;
      end else begin
         ar_rdy <= !ar_rdy && S_AXI_ARVALID && !r_vld;
         if (rd_en) begin
            r_vld  <= 1'b1;
            r_data <= rd_val;
            r_resp <= rd_ok ? 2'b00 : 2'b10;
         end else if (r_vld && S_AXI_RREADY) begin
            r_vld  <= 1'b0;
         end
      end
   end

`ifdef SEVENSEG_BLINK_EN
   // Bit 5 of the frame counter flips every 32 frames and doubles as the blink phase
   assign blank_eff = blank_mask | (frame_cnt[5] ? blink_mask : 8'h00);
`else
   assign blank_eff = blank_mask;
`endif

   always_comb begin
      digit_on = en && !blank_eff[idx];
      lit      = digit_on && (pwm <= bright);
      seg_raw  = hex_decode(digits[{idx, 2'b00} +: 4]);
      an_sel   = 8'h01 << idx;
      an_one   = lit ? an_sel[NUM_DIGITS-1:0] : '0;
      seg_p0   = digit_on ? (SEG_ACTIVE_LOW ? ~seg_raw : seg_raw) : SEG_OFF;
      dp_p0    = digit_on ? (dp_mask[idx] ^ SEG_ACTIVE_LOW) : DP_OFF;
      an_p0    = AN_ACTIVE_LOW ? ~an_one : an_one;
   end

   // Scan engine and output register stage: segments and anodes update on the same edge
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         presc     <= '0;
         idx       <= 3'd0;
         pwm       <= 4'd0;
         frame_cnt <= 16'd0;
         tick_p1   <= 1'b0;
         seg_p1    <= SEG_OFF;
         dp_p1     <= DP_OFF;
         an_p1     <= AN_OFF;
      end else begin
         pwm     <= pwm + 4'd1;
         tick_p1 <= 1'b0;
         if (!en) begin
            presc <= '0;
            idx   <= 3'd0;
         end else if (presc == PRESC_LAST) begin
            presc <= '0;
            if (idx == IDX_LAST) begin
               idx       <= 3'd0;
               tick_p1   <= 1'b1;
               frame_cnt <= frame_cnt + 16'd1;
            end else begin
               idx <= idx + 3'd1;
            end
         end else begin
            presc <= presc + 1'b1;
         end
         seg_p1 <= seg_p0;
         dp_p1  <= dp_p0;
         an_p1  <= an_p0;
      end
   end

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = aw_rdy;
   assign S_AXI_BVALID  = b_vld;
   assign S_AXI_BRESP   = b_resp;
   assign S_AXI_ARREADY = ar_rdy;
   assign S_AXI_RVALID  = r_vld;
   assign S_AXI_RDATA   = r_data;
   assign S_AXI_RRESP   = r_resp;
   assign seg           = seg_p1;
   assign dp            = dp_p1;
   assign an            = an_p1;
   assign frame_tick    = tick_p1;

endmodule

// File: tb/tb_sevenseg_axil_scan.sv
// Directed bench for sevenseg_axil_scan: 4 digits, 16-cycle slots, active-low pins.

module tb_sevenseg_axil_scan;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [4:0]  S_AXI_AWADDR = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b0;
   logic [4:0]  S_AXI_ARADDR = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   int ncmp = 0;
   int nfail = 0;
   int tb_frames = 0;

   sevenseg_axil_scan #(
      .NUM_DIGITS(4), .SCAN_DIV(16), .C_S_AXI_ADDR_WIDTH(5),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
      .S_AXI_RREADY(S_AXI_RREADY),
      .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
   );

   always #5 ACLK = ~ACLK;

   // Independent frame count, used to predict the STATUS frame counter
   always @(negedge ACLK) begin
      if (ARESET) tb_frames <= 0;
      else if (frame_tick) tb_frames <= tb_frames + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic wait_awready(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 32 && !ok; n++) begin
         if (S_AXI_AWREADY) ok = 1'b1;
         step();
      end
   endtask

   task automatic wait_arready(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 32 && !ok; n++) begin
         if (S_AXI_ARREADY) ok = 1'b1;
         step();
      end
   endtask

   task automatic wait_bvalid(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 32 && !ok; n++) begin
         if (S_AXI_BVALID) ok = 1'b1;
         else step();
      end
   endtask

   task automatic wait_rvalid(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 32 && !ok; n++) begin
         if (S_AXI_RVALID) ok = 1'b1;
         else step();
      end
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
      logic ok;
      S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
      wait_awready(ok);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check("aw_handshake", {31'h0, ok}, 32'h1);
      wait_bvalid(ok);
      check("b_handshake", {31'h0, ok}, 32'h1);
      resp = S_AXI_BRESP;
      step();
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
      logic ok;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
      wait_arready(ok);
      S_AXI_ARVALID = 1'b0;
      check("ar_handshake", {31'h0, ok}, 32'h1);
      wait_rvalid(ok);
      check("r_handshake", {31'h0, ok}, 32'h1);
      data = S_AXI_RDATA;
      resp = S_AXI_RRESP;
      step();
   endtask

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;
      logic [31:0] status0;
      logic        ok;
      logic        found;
      logic [3:0]  an_s [1:64];
      logic [6:0]  seg_s [1:64];
      logic        dp_s [1:64];
      logic        ft_s [1:64];
      int          cnt0, cnt1, cnt2, cnt3, cntft, bad;

      // Reset values
      repeat (3) step();
      ARESET = 1'b0;
      check("rst_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
      check("rst_wready",  {31'h0, S_AXI_WREADY},  32'h0);
      check("rst_bvalid",  {31'h0, S_AXI_BVALID},  32'h0);
      check("rst_arready", {31'h0, S_AXI_ARREADY}, 32'h0);
      check("rst_rvalid",  {31'h0, S_AXI_RVALID},  32'h0);
      check("rst_bresp",   {30'h0, S_AXI_BRESP},   32'h0);
      check("rst_rresp",   {30'h0, S_AXI_RRESP},   32'h0);
      check("rst_seg",     {25'h0, seg},           32'h7F);
      check("rst_dp",      {31'h0, dp},            32'h1);
      check("rst_an",      {28'h0, an},            32'hF);
      check("rst_tick",    {31'h0, frame_tick},    32'h0);

      // Register programming and read-back
      axi_write(5'h00, 32'h0000_0001, 4'hF, resp); check("wr_ctrl_bresp", {30'h0, resp}, 32'h0);
      axi_write(5'h04, 32'h0000_001F, 4'hF, resp); check("wr_dig_bresp",  {30'h0, resp}, 32'h0);
      axi_write(5'h08, 32'h0000_0003, 4'hF, resp); check("wr_dp_bresp",   {30'h0, resp}, 32'h0);
      axi_write(5'h0C, 32'h0000_000A, 4'hF, resp); check("wr_blk_bresp",  {30'h0, resp}, 32'h0);
      axi_read(5'h00, rd, resp); check("rd_ctrl", rd, 32'h1);   check("rd_ctrl_rresp", {30'h0, resp}, 32'h0);
      axi_read(5'h04, rd, resp); check("rd_dig", rd, 32'h1F);   check("rd_dig_rresp",  {30'h0, resp}, 32'h0);
      axi_read(5'h08, rd, resp); check("rd_dp", rd, 32'h3);     check("rd_dp_rresp",   {30'h0, resp}, 32'h0);
      axi_read(5'h0C, rd, resp); check("rd_blank", rd, 32'hA);  check("rd_blk_rresp",  {30'h0, resp}, 32'h0);
      axi_write(5'h08, 32'hFFFF_FFF3, 4'hF, resp);
      axi_read(5'h08, rd, resp); check("rd_dp_unused_bits", rd, 32'h3);

      // Full brightness scan over one frame
      axi_write(5'h00, 32'h0000_0F01, 4'hF, resp);
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         step();
         if (frame_tick) found = 1'b1;
      end
      check("frame_tick_seen", {31'h0, found}, 32'h1);
      for (int k = 1; k <= 64; k++) begin
         step();
         an_s[k] = an; seg_s[k] = seg; dp_s[k] = dp; ft_s[k] = frame_tick;
      end
      cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0; cntft = 0;
      for (int k = 1; k <= 16; k++) if (an_s[k] == 4'b1110) cnt0++;
      for (int k = 17; k <= 32; k++) if (an_s[k] == 4'b1111) cnt1++;
      for (int k = 33; k <= 48; k++) if (an_s[k] == 4'b1011) cnt2++;
      for (int k = 49; k <= 64; k++) if (an_s[k] == 4'b1111) cnt3++;
      for (int k = 1; k <= 64; k++) if (ft_s[k]) cntft++;
      check("slot0_an_cycles", cnt0, 16);
      check("slot1_blank_cycles", cnt1, 16);
      check("slot2_an_cycles", cnt2, 16);
      check("slot3_blank_cycles", cnt3, 16);
      check("digit0_seg_F", {25'h0, seg_s[1]}, 32'h0E);
      check("digit0_dp_on", {31'h0, dp_s[1]}, 32'h0);
      check("digit2_seg_0", {25'h0, seg_s[40]}, 32'h40);
      check("digit2_dp_off", {31'h0, dp_s[40]}, 32'h1);
      check("frame_tick_count", cntft, 1);
      check("frame_tick_at_64", {31'h0, ft_s[64]}, 32'h1);

      // PWM brightness 3: each visible digit lit 4 of its 16 cycles
      axi_write(5'h00, 32'h0000_0301, 4'hF, resp);
      cnt0 = 0; cnt2 = 0; bad = 0;
      for (int k = 0; k < 64; k++) begin
         step();
         if (!an[0]) cnt0++;
         if (!an[2]) cnt2++;
         if (!an[1] || !an[3]) bad++;
      end
      check("pwm_digit0_lit", cnt0, 4);
      check("pwm_digit2_lit", cnt2, 4);
      check("pwm_blanked_lit", bad, 0);

      // Disabled display, STATUS and error responses
      axi_write(5'h00, 32'h0000_0000, 4'hF, resp);
      step(); step();
      check("off_an", {28'h0, an}, 32'hF);
      check("off_seg", {25'h0, seg}, 32'h7F);
      check("off_dp", {31'h0, dp}, 32'h1);
      axi_read(5'h10, status0, resp);
      check("status_rresp", {30'h0, resp}, 32'h0);
      check("status_idx", {29'h0, status0[2:0]}, 32'h0);
      check("status_frames", {16'h0, status0[31:16]}, {16'h0, tb_frames[15:0]});
      axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, resp); check("wr_status_bresp", {30'h0, resp}, 32'h2);
      axi_read(5'h10, rd, resp); check("status_unchanged", rd, status0);
      axi_write(5'h18, 32'h1234_5678, 4'hF, resp); check("wr_unmapped_bresp", {30'h0, resp}, 32'h2);
      axi_read(5'h18, rd, resp);
      check("rd_unmapped_data", rd, 32'h0);
      check("rd_unmapped_rresp", {30'h0, resp}, 32'h2);
`ifdef SEVENSEG_BLINK_EN
      axi_write(5'h14, 32'h0000_00FF, 4'hF, resp); check("wr_blink_bresp", {30'h0, resp}, 32'h0);
      axi_read(5'h14, rd, resp);
      check("rd_blink_data", rd, 32'hF);
      check("rd_blink_rresp", {30'h0, resp}, 32'h0);
`else
      axi_write(5'h14, 32'h0000_00FF, 4'hF, resp); check("wr_0x14_bresp", {30'h0, resp}, 32'h2);
      axi_read(5'h14, rd, resp);
      check("rd_0x14_data", rd, 32'h0);
      check("rd_0x14_rresp", {30'h0, resp}, 32'h2);
`endif

      // Back-pressure on B blocks the next write
      S_AXI_BREADY = 1'b0;
      S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h0000_1234; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      wait_awready(ok);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check("hold_aw_handshake", {31'h0, ok}, 32'h1);
      cnt0 = 0;
      for (int k = 0; k < 5; k++) begin
         if (S_AXI_BVALID) cnt0++;
         step();
      end
      check("bvalid_held", cnt0, 5);
      check("hold_bresp", {30'h0, S_AXI_BRESP}, 32'h0);
      S_AXI_WDATA = 32'h0000_5678; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         if (S_AXI_AWREADY || S_AXI_WREADY) bad++;
         step();
      end
      check("second_aw_blocked", bad, 0);
      S_AXI_BREADY = 1'b1;
      wait_awready(ok);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check("second_aw_handshake", {31'h0, ok}, 32'h1);
      wait_bvalid(ok);
      check("second_b_handshake", {31'h0, ok}, 32'h1);
      step();
      axi_read(5'h04, rd, resp); check("rd_dig_second", rd, 32'h0000_5678);
      axi_write(5'h04, 32'hAABB_CCDD, 4'b0100, resp);
      axi_read(5'h04, rd, resp); check("rd_dig_wstrb", rd, 32'h00BB_5678);

      // Reset mid-frame with a read response pending
      axi_write(5'h00, 32'h0000_0F01, 4'hF, resp);
      repeat (10) step();
      S_AXI_RREADY = 1'b0; S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1;
      wait_arready(ok);
      S_AXI_ARVALID = 1'b0;
      wait_rvalid(ok);
      check("pend_rvalid", {31'h0, ok}, 32'h1);
      check("pend_rdata", S_AXI_RDATA, 32'h0000_0F01);
      step(); step();
      check("pend_rvalid_held", {31'h0, S_AXI_RVALID}, 32'h1);
      ARESET = 1'b1;
      step();
      check("mid_rst_rvalid", {31'h0, S_AXI_RVALID}, 32'h0);
      check("mid_rst_an", {28'h0, an}, 32'hF);
      check("mid_rst_seg", {25'h0, seg}, 32'h7F);
      check("mid_rst_dp", {31'h0, dp}, 32'h1);
      check("mid_rst_tick", {31'h0, frame_tick}, 32'h0);
      ARESET = 1'b0;
      step();
      axi_read(5'h00, rd, resp); check("post_rst_ctrl", rd, 32'h0);
      axi_read(5'h04, rd, resp); check("post_rst_digits", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
